conv2d_stream: RTL and testbench

Streaming 2-D KxK convolution engine for raster-ordered unsigned pixels, successor to the fixed 8-bit 3x3 core. Adds a parametrised image geometry, internal line buffers, runtime-programmable signed weights with frame-aligned commit, and ready/valid backpressure on both sides. Produces "valid"-mode output: one result per fully-covered window, (IMG_H-K+1)*(IMG_W-K+1) results per frame. Sits between the pixel source and downstream feature/quantisation stages.

---
 rtl/conv2d_stream.sv | 189 ++++++++++++++++++
 tb/tb_conv2d_stream.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv2d_stream.sv
// conv2d_stream: streaming KxK "valid"-mode convolution over raster-ordered
// unsigned pixels. It keeps K-1 line buffers and a KxK window. Signed weights
// sit in a shadow bank and are committed to the active bank at frame start.
// Results pass through a two-stage product/sum pipeline under ready/valid
// flow control.
// Optional build macro: CONV2D_STREAM_RELU_EN (clamp negative results to 0).
module conv2d_stream #(
  parameter int DATA_WIDTH  = 8,
  parameter int COEF_WIDTH  = 8,
  parameter int OUT_WIDTH   = 8,
  parameter int KERNEL_SIZE = 3,
  parameter int IMG_W       = 64,
  parameter int IMG_H       = 64,
  parameter int SHIFT       = 0
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic [DATA_WIDTH-1:0]                         pixel_in,
  input  logic                                          valid_in,
  output logic                                          ready_in,
  input  logic                                          coef_we,
  input  logic [$clog2(KERNEL_SIZE*KERNEL_SIZE)-1:0]    coef_addr,
  input  logic signed [COEF_WIDTH-1:0]                  coef_data,
  output logic signed [OUT_WIDTH-1:0]                   conv_out,
  output logic                                          valid_out,
  input  logic                                          ready_out,
  output logic                                          last_out
);

  localparam int K      = KERNEL_SIZE;
  localparam int NT     = K * K;
  localparam int AW     = $clog2(NT);
  localparam int CW     = $clog2(IMG_W);
  localparam int RW     = $clog2(IMG_H);
  localparam int PW     = DATA_WIDTH + 1 + COEF_WIDTH;
  localparam int ACC_W  = PW + $clog2(NT);
  localparam int CENTRE = (NT - 1) / 2;
  localparam logic signed [COEF_WIDTH-1:0] ID_COEF = COEF_WIDTH'(1 << SHIFT);
  localparam logic signed [ACC_W-1:0]      SAT_MAX = ACC_W'((1 << (OUT_WIDTH - 1)) - 1);
  localparam logic signed [ACC_W-1:0]      SAT_MIN = ACC_W'(-(1 << (OUT_WIDTH - 1)));

  logic                          advance, accept, frame_start;
  logic                          col_last, row_last, win_ok;
  logic [CW-1:0]                 col_q, col_d;
  logic [RW-1:0]                 row_q, row_d;
  logic [DATA_WIDTH-1:0]         lb_rd   [K-1];
  logic [DATA_WIDTH-1:0]         new_col [K];
  logic [DATA_WIDTH-1:0]         win_q   [K][K];
  logic signed [COEF_WIDTH-1:0]  shadow_q [NT];
  logic signed [COEF_WIDTH-1:0]  active_q [NT];
  logic signed [PW-1:0]          prod_d [NT];
  logic signed [PW-1:0]          prod_q [NT];
  logic                          win_vld_q, win_last_q, p1_vld_q, p1_last_q;
  logic signed [ACC_W-1:0]       sum_d, shift_d;
  logic signed [OUT_WIDTH-1:0]   sat_d, conv_q;
  logic                          valid_q, last_q;

  // The pipeline is stalled only while a held result is refused downstream.
  assign ready_in    = ready_out | ~valid_q;
  assign advance     = ready_in;
  assign accept      = valid_in & ready_in;
  assign col_last    = (col_q == CW'(IMG_W - 1));
  assign row_last    = (row_q == RW'(IMG_H - 1));
  assign frame_start = accept && (col_q == '0) && (row_q == '0);
  assign win_ok      = (col_q >= CW'(K - 1)) && (row_q >= RW'(K - 1));

  assign conv_out  = conv_q;
  assign valid_out = valid_q;
  assign last_out  = last_q;

  // Raster position of the next pixel to be accepted.
  always_comb begin
    col_d = col_q + CW'(1);
    row_d = row_q;
    if (col_last) begin
      col_d = '0;
      row_d = row_last ? '0 : row_q + RW'(1);
    end
  end

  // Raster position register, stepped once per accepted pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else if (accept) begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  // Line buffers: line 0 is the oldest row, line K-2 the row just above the
  // incoming pixel. Each accept pushes the column one line up.
  genvar gi;
  generate
    for (gi = 0; gi < K - 1; gi++) begin : g_line
      logic [DATA_WIDTH-1:0] mem [IMG_W];
      assign lb_rd[gi] = mem[col_q];
      if (gi == K - 2) begin : g_newest
        // newest stored line takes the incoming pixel
        always_ff @(posedge clk) if (accept) mem[col_q] <= pixel_in;
      end else begin : g_older
        // older line inherits the column from the line below it
        always_ff @(posedge clk) if (accept) mem[col_q] <= lb_rd[gi+1];
      end
    end
  endgenerate

  // Column entering the window: stored lines on top, live pixel at the bottom.
  always_comb begin
    for (int r = 0; r < K - 1; r++) new_col[r] = lb_rd[r];
    new_col[K-1] = pixel_in;
  end

  // Window register: shifts left one column per accepted pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++) win_q[r][c] <= '0;
    end else if (accept) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) win_q[r][c] <= win_q[r][c+1];
        win_q[r][K-1] <= new_col[r];
      end
    end
  end

  // Weight banks: writes go to shadow; shadow is committed on the frame's first pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NT; i++) begin
        shadow_q[i] <= (i == CENTRE) ? ID_COEF : '0;
        active_q[i] <= (i == CENTRE) ? ID_COEF : '0;
      end
    end else begin
      if (coef_we && (coef_addr < AW'(NT))) shadow_q[coef_addr] <= coef_data;
      if (frame_start) begin
        for (int i = 0; i < NT; i++) active_q[i] <= shadow_q[i];
      end
    end
  end

  // Per-tap product: zero-extended pixel times sign-extended weight.
  generate
    for (gi = 0; gi < NT; gi++) begin : g_tap
      assign prod_d[gi] = $signed({{COEF_WIDTH{1'b0}}, 1'b0, win_q[gi / K][gi % K]}) *
                          $signed({{(DATA_WIDTH + 1){active_q[gi][COEF_WIDTH-1]}}, active_q[gi]});
    end
  endgenerate

  // Sum of products, floor shift, optional ReLU, then saturation.
  always_comb begin
    sum_d = '0;
    for (int i = 0; i < NT; i++) sum_d = sum_d + ACC_W'(prod_q[i]);
    shift_d = sum_d >>> SHIFT;
`ifdef CONV2D_STREAM_RELU_EN
    if (shift_d[ACC_W-1]) shift_d = '0;
`endif
    if (shift_d > SAT_MAX)      sat_d = SAT_MAX[OUT_WIDTH-1:0];
    else if (shift_d < SAT_MIN) sat_d = SAT_MIN[OUT_WIDTH-1:0];
    else                        sat_d = shift_d[OUT_WIDTH-1:0];
  end

  // Window -> products -> output pipeline, frozen as a whole during a stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_vld_q  <= 1'b0;
      win_last_q <= 1'b0;
      p1_vld_q   <= 1'b0;
      p1_last_q  <= 1'b0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      conv_q     <= '0;
      for (int i = 0; i < NT; i++) prod_q[i] <= '0;
    end else if (advance) begin
      win_vld_q  <= accept & win_ok;
      win_last_q <= accept & col_last & row_last;
      p1_vld_q   <= win_vld_q;
      p1_last_q  <= win_last_q;
      if (win_vld_q) begin
        for (int i = 0; i < NT; i++) prod_q[i] <= prod_d[i];
      end
      valid_q <= p1_vld_q;
      last_q  <= p1_last_q;
      if (p1_vld_q) conv_q <= sat_d;
    end
  end

endmodule

// File: tb/tb_conv2d_stream.sv
// Bench for conv2d_stream on a 5x4 image. Two instances (SHIFT=0 and SHIFT=4)
// share all inputs, and their results are checked against a windowed-sum reference.
module tb_conv2d_stream;
  localparam int W = 5, H = 4, K = 3, NT = 9;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]        pixel_in = '0;
  logic              valid_in = 1'b0, ready_out = 1'b1, coef_we = 1'b0;
  logic [3:0]        coef_addr = '0;
  logic signed [7:0] coef_data = '0;
  logic              ready_in0, ready_in4, valid_out0, valid_out4, last_out0, last_out4;
  logic signed [7:0] conv_out0, conv_out4;

  conv2d_stream #(.IMG_W(W), .IMG_H(H), .SHIFT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .pixel_in(pixel_in), .valid_in(valid_in), .ready_in(ready_in0),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data), .conv_out(conv_out0),
    .valid_out(valid_out0), .ready_out(ready_out), .last_out(last_out0));
  conv2d_stream #(.IMG_W(W), .IMG_H(H), .SHIFT(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .pixel_in(pixel_in), .valid_in(valid_in), .ready_in(ready_in4),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data), .conv_out(conv_out4),
    .valid_out(valid_out4), .ready_out(ready_out), .last_out(last_out4));

  int n_checks = 0, n_fail = 0, cyc_n = 0;
  always @(posedge clk) cyc_n++;

  // reference model state
  int img [H][W];
  int shadow0 [NT], shadow4 [NT], frame_w0 [NT], frame_w4 [NT], new_w [NT];
  int acc_edge [W*H];
  int exp0 [$], exp4 [$];
  bit explast [$];

  // observed output transfers
  int got0 [$], got4 [$], gotcyc [$];
  bit gotlast [$], gotv4 [$];

  always @(negedge clk) begin
    #2;
    if (rst_n && valid_out0 && ready_out) begin
      got0.push_back(int'(conv_out0));
      got4.push_back(int'(conv_out4));
      gotlast.push_back(last_out0);
      gotv4.push_back(valid_out4 && (last_out4 == last_out0));
      gotcyc.push_back(cyc_n);
      $display("xfer cyc=%0d dut0=%0d dut4=%0d last=%0b", cyc_n, conv_out0, conv_out4, last_out0);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got=%0d required=finish", cyc_n);
    $fatal(1, "watchdog");
  end

  function automatic int ref_out(int r, int c, int sh, bit use4);
    int s = 0;
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++)
        s += img[r-K+1+i][c-K+1+j] * (use4 ? frame_w4[i*K+j] : frame_w0[i*K+j]);
    s = s >>> sh;
`ifdef CONV2D_STREAM_RELU_EN
    if (s < 0) s = 0;
`endif
    if (s > 127) s = 127;
    if (s < -128) s = -128;
    return s;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NT; i++) begin
      shadow0[i] = (i == 4) ? 1 : 0;
      shadow4[i] = (i == 4) ? 16 : 0;
    end
  endfunction

  function automatic void clear_queues();
    got0.delete(); got4.delete(); gotlast.delete(); gotv4.delete(); gotcyc.delete();
    exp0.delete(); exp4.delete(); explast.delete();
  endfunction

  task automatic cyc(input bit v, input int pix, input bit ro, input bit cw,
                     input int ca, input int cd, output bit acc);
    @(negedge clk);
    valid_in  = v;
    pixel_in  = 8'(pix);
    ready_out = ro;
    coef_we   = cw;
    coef_addr = 4'(ca);
    coef_data = 8'(cd);
    #1;
    acc = v && ready_in0;
  endtask

  task automatic drain(input int n);
    bit acc;
    repeat (n) cyc(0, 0, 1, 0, 0, 0, acc);
  endtask

  task automatic load_weights();
    bit acc;
    for (int a = 0; a < NT; a++) begin
      cyc(0, 0, 1, 1, a, new_w[a], acc);
      shadow0[a] = new_w[a];
      shadow4[a] = new_w[a];
    end
  endtask

  // Streams one frame of img; weights latched by the model at the first pixel.
  task automatic drive_frame(input int idle_pct, input int stall_at, input int mid_wr_at,
                             input bit first_wr, input int fw_addr, input int fw_data);
    int p = 0, tries = 0, stall_left = 0, held = 0;
    bit acc, v, ro, have_held = 0, stall_done = 0, wrote = 0;
    frame_w0 = shadow0;
    frame_w4 = shadow4;
    for (int r = K - 1; r < H; r++)
      for (int c = K - 1; c < W; c++) begin
        exp0.push_back(ref_out(r, c, 0, 0));
        exp4.push_back(ref_out(r, c, 4, 1));
        explast.push_back(r == H - 1 && c == W - 1);
      end
    while (p < W * H) begin
      if (p == mid_wr_at && !wrote) begin
        load_weights();
        cyc(0, 0, 1, 1, 9 + $urandom_range(6), $urandom_range(255), acc);
        wrote = 1;
      end
      if (p == stall_at && !stall_done) begin
        stall_left = 5;
        stall_done = 1;
      end
      if (stall_left > 0) begin
        cyc(1, img[p/W][p%W], 0, 0, 0, 0, acc);
        stall_left--;
        if (valid_out0) begin
          if (!have_held) begin
            held = int'(conv_out0);
            have_held = 1;
          end
          n_checks++;
          if (ready_in0 !== 1'b0 || acc) begin
            n_fail++;
            $display("FAIL stall_ready_in: got ready_in=%0b required 0", ready_in0);
          end
          n_checks++;
          if (int'(conv_out0) !== held) begin
            n_fail++;
            $display("FAIL stall_hold: got conv_out=%0d required %0d", conv_out0, held);
          end
        end
      end else if (p == 0 && first_wr) begin
        cyc(1, img[0][0], 1, 1, fw_addr, fw_data, acc);
        if (fw_addr < NT) begin
          shadow0[fw_addr] = fw_data;
          shadow4[fw_addr] = fw_data;
        end
      end else begin
        v  = ($urandom_range(99) >= idle_pct);
        ro = ($urandom_range(99) >= idle_pct);
        cyc(v, img[p/W][p%W], ro, 0, 0, 0, acc);
      end
      if (acc) begin
        acc_edge[p] = cyc_n + 1;
        p++;
      end
      tries++;
      if (tries > 500) begin
        n_checks++;
        n_fail++;
        $display("FAIL frame_timeout: got %0d pixels accepted required %0d", p, W * H);
        break;
      end
    end
  endtask

  task automatic check_results(input string name);
    n_checks++;
    if (got0.size() != exp0.size()) begin
      n_fail++;
      $display("FAIL %s_count: got %0d results required %0d", name, got0.size(), exp0.size());
    end
    for (int i = 0; i < got0.size() && i < exp0.size(); i++) begin
      n_checks++;
      if (got0[i] !== exp0[i] || got4[i] !== exp4[i] || gotlast[i] !== explast[i] || gotv4[i] !== 1'b1) begin
        n_fail++;
        $display("FAIL %s[%0d]: got s0=%0d s4=%0d last=%0b v4ok=%0b required s0=%0d s4=%0d last=%0b",
                 name, i, got0[i], got4[i], gotlast[i], gotv4[i], exp0[i], exp4[i], explast[i]);
      end
    end
    clear_queues();
  endtask

  task automatic test_reset();
    bit acc;
    repeat (3) @(negedge clk);
    for (int phase = 0; phase < 2; phase++) begin
      n_checks++;
      if (valid_out0 !== 1'b0 || valid_out4 !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_valid: got %0b/%0b required 0", valid_out0, valid_out4);
      end
      n_checks++;
      if (last_out0 !== 1'b0 || last_out4 !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_last: got %0b/%0b required 0", last_out0, last_out4);
      end
      n_checks++;
      if (conv_out0 !== 8'sd0 || conv_out4 !== 8'sd0) begin
        n_fail++;
        $display("FAIL reset_conv_out: got %0d/%0d required 0", conv_out0, conv_out4);
      end
      n_checks++;
      if (ready_in0 !== 1'b1 || ready_in4 !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_ready_in: got %0b/%0b required 1", ready_in0, ready_in4);
      end
      if (phase == 0) begin
        rst_n = 1'b1;
        cyc(0, 0, 1, 0, 0, 0, acc);
      end
    end
    model_reset();
    clear_queues();
  endtask

  task automatic test_identity_latency();
    int id_tab [6] = '{11, 12, 13, 21, 22, 23};
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) img[r][c] = 10 * r + c;
    drive_frame(0, -1, -1, 0, 0, 0);
    drain(8);
    n_checks++;
    if (gotcyc.size() == 0 || gotcyc[0] != acc_edge[2*W+2] + 2) begin
      n_fail++;
      $display("FAIL latency: got first result at cycle %0d required %0d",
               (gotcyc.size() > 0) ? gotcyc[0] : -1, acc_edge[2*W+2] + 2);
    end
    for (int i = 0; i < 6 && i < got0.size(); i++) begin
      n_checks++;
      if (got0[i] != id_tab[i] || got4[i] != id_tab[i] || gotlast[i] != (i == 5)) begin
        n_fail++;
        $display("FAIL identity[%0d]: got %0d/%0d last=%0b required %0d last=%0b",
                 i, got0[i], got4[i], gotlast[i], id_tab[i], (i == 5));
      end
    end
    check_results("identity");
  endtask

  task automatic test_sum_saturation();
    for (int a = 0; a < NT; a++) new_w[a] = 1;
    load_weights();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) img[r][c] = 255;
    drive_frame(20, -1, -1, 0, 0, 0);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) img[r][c] = 10;
    drive_frame(20, -1, -1, 0, 0, 0);
    drain(8);
    check_results("sum_sat");
  endtask

  task automatic test_negative();
    for (int a = 0; a < NT; a++) new_w[a] = (a == 4) ? -1 : 0;
    load_weights();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) img[r][c] = 200;
    drive_frame(10, -1, -1, 0, 0, 0);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) img[r][c] = 3;
    drive_frame(10, -1, -1, 0, 0, 0);
    drain(8);
    check_results("negative");
  endtask

  task automatic test_backpressure();
    for (int a = 0; a < NT; a++) new_w[a] = int'($urandom_range(6)) - 3;
    load_weights();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) img[r][c] = $urandom_range(255);
    drive_frame(0, 13, -1, 0, 0, 0);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) img[r][c] = $urandom_range(255);
    drive_frame(35, -1, -1, 0, 0, 0);
    drain(10);
    check_results("backpressure");
  endtask

  task automatic test_midframe_weights();
    for (int a = 0; a < NT; a++) new_w[a] = $urandom_range(2);
    load_weights();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) img[r][c] = $urandom_range(20);
    for (int a = 0; a < NT; a++) new_w[a] = int'($urandom_range(8)) - 4;
    new_w[0] = 3;
    drive_frame(10, -1, 10, 0, 0, 0);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) img[r][c] = $urandom_range(20);
    drive_frame(10, -1, -1, 1, 4, 37);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) img[r][c] = $urandom_range(20);
    drive_frame(0, -1, -1, 0, 0, 0);
    drain(8);
    check_results("weight_commit");
  endtask

  task automatic test_reset_midframe();
    bit acc;
    int tries;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) img[r][c] = $urandom_range(255);
    for (int p = 0; p < 2 * W + 3; p++) begin
      acc = 0;
      tries = 0;
      while (!acc && tries < 20) begin
        cyc(1, img[p/W][p%W], 1, 0, 0, 0, acc);
        tries++;
      end
    end
    repeat (3) cyc(0, 0, 0, 0, 0, 0, acc);
    n_checks++;
    if (valid_out0 !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_valid: got %0b required 1", valid_out0);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (valid_out0 !== 1'b0 || valid_out4 !== 1'b0 || last_out0 !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_valid: got %0b/%0b last=%0b required 0", valid_out0, valid_out4, last_out0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    clear_queues();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) img[r][c] = $urandom_range(255);
    drive_frame(15, -1, -1, 0, 0, 0);
    drain(8);
    check_results("after_reset");
  endtask

  initial begin
    test_reset();
    test_identity_latency();
    test_sum_saturation();
    test_negative();
    test_backpressure();
    test_midframe_weights();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
